// File: rtl/seg_scan_driver.sv
// Time-multiplexes six frame-latched glyph codes onto a common-anode 7-segment bank.
// Per-digit blink is compiled in only when the SEG_BLINK_EN macro is defined.
module seg_scan_driver #(
  parameter int CLK_HZ           = 100_000_000,
  parameter int SCAN_HZ          = 1_000,
  parameter int BLINK_HZ         = 2,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] seg1,
  input  logic [5:0] seg2,
  input  logic [5:0] seg3,
  input  logic [5:0] seg4,
  input  logic [5:0] seg5,
  input  logic [5:0] seg6,
  input  logic [7:0] twinkle,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int              SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int              SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [7:0]      AN_OFF    = ANODE_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [SCAN_W-1:0] scan_cnt_q;
  logic [2:0]        idx_q, idx_d;
  logic              pend_q;
  logic [5:0][5:0]   code_q, code_d;
  logic [7:0]        an_q, seg_q;
  logic [7:0]        seg_raw;
  logic              tick, wrap, blank_d;

  function automatic logic [6:0] glyph(input logic [5:0] code);
    case (code)
      6'd0:    glyph = 7'h3F;
      6'd1:    glyph = 7'h06;
      6'd2:    glyph = 7'h5B;
      6'd3:    glyph = 7'h4F;
      6'd4:    glyph = 7'h66;
      6'd5:    glyph = 7'h6D;
      6'd6:    glyph = 7'h7D;
      6'd7:    glyph = 7'h07;
      6'd8:    glyph = 7'h7F;
      6'd9:    glyph = 7'h6F;
      6'd11:   glyph = 7'h77;
      6'd12:   glyph = 7'h7C;
      6'd13:   glyph = 7'h39;
      6'd14:   glyph = 7'h5E;
      6'd15:   glyph = 7'h79;
      6'd16:   glyph = 7'h71;
      6'd17:   glyph = 7'h40;
      6'd26:   glyph = 7'h73;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign tick   = (scan_cnt_q == SCAN_LAST);
  assign wrap   = tick && (idx_q == 3'd5);
  assign idx_d  = tick ? (wrap ? 3'd0 : idx_q + 3'd1) : idx_q;
  // Shadows reload on the wrap tick; digit 0 of the new frame already uses the fresh codes.
  assign code_d = wrap ? {seg6, seg5, seg4, seg3, seg2, seg1} : code_q;

`ifdef SEG_BLINK_EN
  localparam int                 BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int                 BLINK_W    = $clog2(BLINK_HALF + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_q, phase_d;
  logic [5:0]         tw_q, tw_d;
  logic               unused_tw_hi;

  assign unused_tw_hi = ^twinkle[7:6];
  assign phase_d      = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;
  assign tw_d         = wrap ? twinkle[5:0] : tw_q;
  assign blank_d      = phase_d & tw_d[idx_d];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      tw_q        <= '0;
    end else begin
      blink_cnt_q <= (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BLINK_W'(1);
      phase_q     <= phase_d;
      tw_q        <= tw_d;
    end
  end
`else
  localparam int unused_blink_hz = BLINK_HZ;
  logic          unused_twinkle;

  assign unused_twinkle = ^twinkle;
  assign blank_d        = 1'b0;
`endif

  always_comb begin
    seg_raw = {1'b0, glyph(code_d[idx_d])};
    if (blank_d) seg_raw = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      code_q     <= {6{6'd10}};
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      scan_cnt_q <= tick ? '0 : scan_cnt_q + SCAN_W'(1);
      idx_q      <= idx_d;
      code_q     <= code_d;
      pend_q     <= tick;
      // One dark cycle on every digit change hides ghosting from the segment update.
      if (tick) begin
        an_q <= AN_OFF;
      end else if (pend_q) begin
        an_q <= (8'h01 << idx_q) ^ AN_OFF;
      end
      seg_q <= seg_raw ^ SEG_OFF;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: expected an/seg per cycle are queued with a cycle stamp
// and checked by an independent monitor on the falling edge.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] seg1, seg2, seg3, seg4, seg5, seg6;
  logic [7:0] twinkle;
  logic [7:0] an, seg;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] seg;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   fin = 1'b0;

  seg_scan_driver #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(10),
    .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5), .seg6(seg6),
    .twinkle(twinkle), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen with reset released
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic push(input int c, input logic [7:0] a, input logic [7:0] s, input string n);
    exp_t e;
    e.cyc = c; e.an = a; e.seg = s; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compares every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc || an !== e.an || seg !== e.seg) begin
        failures++;
        $display("FAIL %s cyc=%0d (due %0d): an=%h seg=%h expected an=%h seg=%h",
                 e.name, cyc, e.cyc, an, seg, e.an, e.seg);
      end
    end
    if (fin) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL %s never reached: due cyc=%0d, run ended at cyc=%0d", e.name, e.cyc, cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  logic [7:0] pat_a[6];

  initial begin
    pat_a = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};  // ~glyph of codes 1..6
    seg1 = 6'd1; seg2 = 6'd2; seg3 = 6'd3; seg4 = 6'd4; seg5 = 6'd5; seg6 = 6'd6;
    twinkle = 8'h00;

    // Reset state, blank shadows before the first wrap, first latched frame
    push(0,  8'hFF, 8'hFF, "reset_outputs");
    push(9,  8'hFF, 8'hFF, "pre_first_tick");
    push(10, 8'hFF, 8'hFF, "first_tick_ghost");
    push(11, 8'hFD, 8'hFF, "digit1_blank_shadow");
    push(59, 8'hDF, 8'hFF, "digit5_blank_shadow");
    push(60, 8'hFF, 8'hF9, "wrap_ghost_digit0");
    // Full frame of scan timing with codes 1..6
    for (int k = 61; k <= 120; k++) begin
      int d;
      d = (k / 10) % 6;
      push(k, (k % 10 == 0) ? 8'hFF : ~(8'h01 << d), pat_a[d], "scan_frame");
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Glyph banner latched at cyc 180; mid-frame seg3 change latched at 240
    wait_cyc(125);
    seg1 = 6'd0; seg2 = 6'd26; seg3 = 6'd14; seg4 = 6'd1; seg5 = 6'd10; seg6 = 6'd31;
    push(135, 8'hFD, 8'hA4, "no_tear_digit1");
    push(185, 8'hFE, 8'hC0, "glyph_0");
    push(195, 8'hFD, 8'h8C, "glyph_P");
    push(205, 8'hFB, 8'hA1, "glyph_d_before_change");
    push(215, 8'hF7, 8'hF9, "glyph_1");
    push(225, 8'hEF, 8'hFF, "glyph_blank10");
    push(235, 8'hDF, 8'hFF, "glyph_code31");
    push(265, 8'hFB, 8'h90, "glyph_9_next_frame");
    wait_cyc(193);
    seg3 = 6'd9;

    // Blink on digits 0 and 5 (bits 7:6 also set), latched at cyc 300
    wait_cyc(250);
    twinkle = 8'hE1;
    seg6 = 6'd8;
    push(305, 8'hFE, 8'hC0, "blink_d0_phase0");
`ifdef SEG_BLINK_EN
    push(355, 8'hDF, 8'hFF, "blink_d5_phase1");
    push(365, 8'hFE, 8'hFF, "blink_d0_phase1");
`else
    push(355, 8'hDF, 8'h80, "noblink_d5");
    push(365, 8'hFE, 8'hC0, "noblink_d0");
`endif
    push(375, 8'hFD, 8'h8C, "blink_d1_unaffected");
    push(395, 8'hF7, 8'hF9, "blink_d3_unaffected");
    push(415, 8'hDF, 8'h80, "blink_d5_phase0");

    // Async reset mid-digit, then restart from idx 0 with blank shadows
    wait_cyc(422);
    push(423, 8'hFF, 8'hFF, "async_reset_outputs");
    push(432, 8'hFF, 8'hFF, "rst2_pre_tick");
    push(433, 8'hFF, 8'hFF, "rst2_first_tick");
    push(434, 8'hFD, 8'hFF, "rst2_digit1_blank");
    push(482, 8'hDF, 8'hFF, "rst2_digit5_blank");
    push(493, 8'hFF, 8'h8C, "rst2_digit1_latched_ghost");
    push(494, 8'hFD, 8'h8C, "rst2_digit1_latched");
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wait_cyc(500);
    fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
